// File: rtl/gpu_instruction_dispatcher.sv
// gpu_instruction_dispatcher
//   Pops instructions from the instruction FIFO one at a time, decodes the
//   opcode and hands the latched word to the owning draw engine with a
//   one-cycle start pulse. It stalls while the target engine is busy,
//   drains all engines on SYNC, skips NOP and flags illegal opcodes.
//   Optional feature macro: GPU_DISPATCH_STATS_EN (issue counter on
//   issued_count_o; the port reads 0 when the macro is undefined).
module gpu_instruction_dispatcher #(
  parameter int NUM_ENG    = 3,
  parameter int INSTR_BITS = 79,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty_i,
  input  logic [INSTR_BITS-1:0] instr_i,
  output logic                  pop_instruction_o,
  input  logic                  halt_i,
  input  logic [NUM_ENG-1:0]    eng_busy_i,
  output logic [NUM_ENG-1:0]    eng_start_o,
  output logic [INSTR_BITS-1:0] instr_o,
  output logic                  idle_o,
  output logic                  err_opcode_o,
  output logic [CNT_BITS-1:0]   issued_count_o
);

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LINE   = 4'd1;
  localparam logic [3:0] OP_CIRCLE = 4'd2;
  localparam logic [3:0] OP_RECT   = 4'd3;
  localparam logic [3:0] OP_SYNC   = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_SYNC_WAIT = 2'd3
  } state_t;

  state_t                  state_q;
  logic [INSTR_BITS-1:0]   instr_q;
  logic [NUM_ENG-1:0]      start_q;
  logic                    err_q;

  logic [3:0]              opcode_s;
  logic [NUM_ENG-1:0]      target_s;
  logic                    target_busy_s;
  logic                    pop_s;

  // Map a draw opcode to the one-hot engine that owns it; zero for non-draw opcodes.
  function automatic logic [NUM_ENG-1:0] eng_for_opcode(input logic [3:0] op);
    logic [NUM_ENG-1:0] sel;
    sel = '0;
    case (op)
      OP_LINE:   sel[0] = 1'b1;
      OP_CIRCLE: sel[1] = 1'b1;
      OP_RECT:   sel[2] = 1'b1;
      default:   sel = '0;
    endcase
    return sel;
  endfunction

  assign opcode_s      = instr_q[3:0];
  assign target_s      = eng_for_opcode(opcode_s);
  assign target_busy_s = |(target_s & eng_busy_i);

  // Pop is decoded from state and inputs so the FIFO head is captured on the
  // same edge; it is held off during reset so nothing is consumed then.
  assign pop_s = ~rst & (state_q == ST_IDLE) & ~fifo_empty_i & ~halt_i;

  assign pop_instruction_o = pop_s;
  assign eng_start_o       = start_q;
  assign instr_o           = instr_q;
  assign err_opcode_o      = err_q;
  assign idle_o            = (state_q == ST_IDLE) & fifo_empty_i & (eng_busy_i == '0);

  // Dispatch sequencer: fetch, decode, issue start pulse or drain on SYNC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      start_q <= '0;
      err_q   <= 1'b0;
    end else begin
      start_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            instr_q <= instr_i;
            state_q <= ST_DECODE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DECODE: begin
          case (opcode_s)
            OP_NOP:  state_q <= ST_IDLE;
            OP_SYNC: state_q <= ST_SYNC_WAIT;
            OP_LINE, OP_CIRCLE, OP_RECT: begin
              // Busy falling in this cycle lets the issue go out next cycle.
              if (!target_busy_s) begin
                start_q <= target_s;
                state_q <= ST_ISSUE;
              end else begin
                state_q <= ST_DECODE;
              end
            end
            default: begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          endcase
        end
        ST_ISSUE: begin
          state_q <= ST_IDLE;
        end
        ST_SYNC_WAIT: begin
          // Always spends at least one cycle here, so an engine started just
          // before the SYNC has had time to raise busy.
          if (eng_busy_i == '0) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_SYNC_WAIT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GPU_DISPATCH_STATS_EN
  logic [CNT_BITS-1:0] issued_q;

  // Count every start pulse; wraps naturally at the counter width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
    end else if (|start_q) begin
      issued_q <= issued_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
    end else begin
      issued_q <= issued_q;
    end
  end

  assign issued_count_o = issued_q;
`else
  assign issued_count_o = '0;
`endif

endmodule
